// File: rtl/kinase_pad_sequencer.sv
// kinase_pad_sequencer
//   Runs one command at a time for the kinase-activity chip pad ring.
//   Commands are static valve writes, peristaltic pump strokes, timed waits
//   and a vent (flush) cycle. They arrive on a valid/ready stream.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only in IDLE and out of reset
//   cmd_op, cmd_arg     opcode (0 NOP .. 7 reserved) and argument
//   abort               drops a running command without a done pulse
//   busy, done, err     status: running, 1-cycle completion, sticky bad-op
//   pad_*               registered pad drives; flush lines only high in FLUSH
module kinase_pad_sequencer #(
    parameter int unsigned PHASE_CYCLES = 64,
    parameter int unsigned FLUSH_CYCLES = 256,
    parameter int unsigned ARG_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [12:0]      pad_ctrl_a,
    output logic [3:0]       pad_ctrl_s,
    output logic [2:0]       pad_pump_a,
    output logic [1:0]       pad_pump_b,
    output logic [12:0]      pad_flush_ctrl_a,
    output logic [3:0]       pad_flush_ctrl_s,
    output logic [2:0]       pad_flush_pump_a,
    output logic [1:0]       pad_flush_pump_b
);

    localparam int unsigned PHASE_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] OP_SET_A  = 3'd1;
    localparam logic [2:0] OP_SET_S  = 3'd2;
    localparam logic [2:0] OP_PUMP_A = 3'd3;
    localparam logic [2:0] OP_PUMP_B = 3'd4;
    localparam logic [2:0] OP_WAIT   = 3'd5;
    localparam logic [2:0] OP_FLUSH  = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StPumpA,
        StPumpB,
        StWait,
        StFlush
    } state_e;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [2:0]         phase_idx_q, phase_idx_d;
    // Strokes left (PUMP_*) or cycles left (WAIT). It is loaded with arg and
    // counts down to 1, so arg = all-ones never wraps.
    logic [ARG_W-1:0]   count_q, count_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [12:0]        ctrl_a_q, ctrl_a_d;
    logic [3:0]         ctrl_s_q, ctrl_s_d;
    logic [2:0]         pump_a_q, pump_a_d;
    logic [1:0]         pump_b_q, pump_b_d;
    logic               flush_q, flush_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    function automatic logic [2:0] pump_a_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [1:0] pump_b_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'b10;
            3'd2:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            phase_idx_q <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            ctrl_a_q    <= '0;
            ctrl_s_q    <= '0;
            pump_a_q    <= '0;
            pump_b_q    <= '0;
            flush_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            phase_idx_q <= phase_idx_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            ctrl_a_q    <= ctrl_a_d;
            ctrl_s_q    <= ctrl_s_d;
            pump_a_q    <= pump_a_d;
            pump_b_q    <= pump_b_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        phase_idx_d = phase_idx_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        ctrl_a_d    = ctrl_a_q;
        ctrl_s_d    = ctrl_s_q;
        pump_a_d    = pump_a_q;
        pump_b_d    = pump_b_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    // Single-cycle ops (and zero-length multi-cycle ops) finish here.
                    done_d      = 1'b1;
                    phase_cnt_d = '0;
                    phase_idx_d = '0;
                    count_d     = cmd_arg;
                    case (cmd_op)
                        OP_SET_A: ctrl_a_d = cmd_arg[12:0];
                        OP_SET_S: ctrl_s_d = cmd_arg[3:0];
                        OP_PUMP_A: begin
                            if (cmd_arg != '0) begin
                                state_d  = StPumpA;
                                done_d   = 1'b0;
                                pump_a_d = pump_a_pat(3'd0);
                            end
                        end
                        OP_PUMP_B: begin
                            if (cmd_arg != '0) begin
                                state_d  = StPumpB;
                                done_d   = 1'b0;
                                pump_b_d = pump_b_pat(3'd0);
                            end
                        end
                        OP_WAIT: begin
                            if (cmd_arg != '0) begin
                                state_d = StWait;
                                done_d  = 1'b0;
                            end
                        end
                        OP_FLUSH: begin
                            state_d     = StFlush;
                            done_d      = 1'b0;
                            flush_cnt_d = '0;
                            ctrl_a_d    = '0;
                            ctrl_s_d    = '0;
                            pump_a_d    = '0;
                            pump_b_d    = '0;
                            flush_d     = 1'b1;
                        end
                        OP_RSVD: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StPumpA, StPumpB: begin
                if (phase_cnt_q == PHASE_LAST) begin
                    phase_cnt_d = '0;
                    if (phase_idx_q == ((state_q == StPumpA) ? 3'd5 : 3'd3)) begin
                        phase_idx_d = '0;
                        if (count_q == ARG_W'(1)) begin
                            state_d  = StIdle;
                            done_d   = 1'b1;
                            pump_a_d = '0;
                            pump_b_d = '0;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end else begin
                        phase_idx_d = phase_idx_q + 3'd1;
                    end
                    if (state_d != StIdle) begin
                        if (state_q == StPumpA) begin
                            pump_a_d = pump_a_pat(phase_idx_d);
                        end else begin
                            pump_b_d = pump_b_pat(phase_idx_d);
                        end
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (count_q == ARG_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides any completion in the same cycle. ctrl pads keep their
        // value, which is already 0 if FLUSH was running.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            pump_a_d = '0;
            pump_b_d = '0;
            flush_d  = 1'b0;
            ctrl_a_d = ctrl_a_q;
            ctrl_s_d = ctrl_s_q;
        end
    end

    assign cmd_ready        = (state_q == StIdle) && !rst;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;
    assign err              = err_q;
    assign pad_ctrl_a       = ctrl_a_q;
    assign pad_ctrl_s       = ctrl_s_q;
    assign pad_pump_a       = pump_a_q;
    assign pad_pump_b       = pump_b_q;
    assign pad_flush_ctrl_a = {13{flush_q}};
    assign pad_flush_ctrl_s = {4{flush_q}};
    assign pad_flush_pump_a = {3{flush_q}};
    assign pad_flush_pump_b = {2{flush_q}};

endmodule

// File: tb/tb_kinase_pad_sequencer.sv
// Testbench for kinase_pad_sequencer: directed steps plus random commands,
// each checked cycle by cycle against expected pad waveforms computed from
// the command table.
module tb_kinase_pad_sequencer;

    localparam int P = 4;
    localparam int F = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        abort;
    logic        busy, done, err;
    logic [12:0] pad_ctrl_a, pad_flush_ctrl_a;
    logic [3:0]  pad_ctrl_s, pad_flush_ctrl_s;
    logic [2:0]  pad_pump_a, pad_flush_pump_a;
    logic [1:0]  pad_pump_b, pad_flush_pump_b;

    kinase_pad_sequencer #(
        .PHASE_CYCLES(P),
        .FLUSH_CYCLES(F),
        .ARG_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_arg(cmd_arg),
        .abort(abort),
        .busy(busy),
        .done(done),
        .err(err),
        .pad_ctrl_a(pad_ctrl_a),
        .pad_ctrl_s(pad_ctrl_s),
        .pad_pump_a(pad_pump_a),
        .pad_pump_b(pad_pump_b),
        .pad_flush_ctrl_a(pad_flush_ctrl_a),
        .pad_flush_ctrl_s(pad_flush_ctrl_s),
        .pad_flush_pump_a(pad_flush_pump_a),
        .pad_flush_pump_b(pad_flush_pump_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: values the pads should hold while no pump or flush runs.
    logic [12:0] exp_a;
    logic [3:0]  exp_s;
    logic        exp_err;

    int pat_a[6] = '{4, 6, 2, 3, 1, 5};
    int pat_b[4] = '{2, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input bit eb, input bit ed, input logic [2:0] epa,
                               input logic [1:0] epb, input bit efl);
        check("busy", busy, eb);
        check("done", done, ed);
        check("cmd_ready", cmd_ready, !eb);
        check("err", err, exp_err);
        check("ctrl_a", pad_ctrl_a, exp_a);
        check("ctrl_s", pad_ctrl_s, exp_s);
        check("pump_a", pad_pump_a, epa);
        check("pump_b", pad_pump_b, epb);
        check("flush_ctrl_a", pad_flush_ctrl_a, efl ? 13'h1FFF : 13'h0);
        check("flush_ctrl_s", pad_flush_ctrl_s, efl ? 4'hF : 4'h0);
        check("flush_pump_a", pad_flush_pump_a, efl ? 3'h7 : 3'h0);
        check("flush_pump_b", pad_flush_pump_b, efl ? 2'h3 : 2'h0);
        check("pad_and_flush", {(pad_ctrl_a & pad_flush_ctrl_a) != 0,
                                (pad_ctrl_s & pad_flush_ctrl_s) != 0,
                                (pad_pump_a & pad_flush_pump_a) != 0,
                                (pad_pump_b & pad_flush_pump_b) != 0}, 4'h0);
    endtask

    // Issue one command from IDLE; abort_at selects the busy cycle in which abort
    // is raised (negative or beyond the command length: no abort).
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] arg, input int abort_at);
        int len;
        logic [2:0] epa;
        logic [1:0] epb;
        check("ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        len = 0;
        case (op)
            3'd1: exp_a = arg[12:0];
            3'd2: exp_s = arg[3:0];
            3'd3: len = 6 * P * int'(arg);
            3'd4: len = 4 * P * int'(arg);
            3'd5: len = int'(arg);
            3'd6: begin
                len   = F;
                exp_a = '0;
                exp_s = '0;
            end
            3'd7: exp_err = 1'b1;
            default: ;
        endcase
        step();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = '0;
        for (int k = 0; k < len; k++) begin
            epa = (op == 3'd3) ? 3'(pat_a[(k / P) % 6]) : 3'd0;
            epb = (op == 3'd4) ? 2'(pat_b[(k / P) % 4]) : 2'd0;
            check_cycle(1'b1, 1'b0, epa, epb, op == 3'd6);
            if (k == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check_cycle(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
                return;
            end
            step();
        end
        check_cycle(1'b0, 1'b1, 3'd0, 2'd0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [15:0] rarg;
        int          rab;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = '0;
        abort     = 1'b0;
        exp_a     = '0;
        exp_s     = '0;
        exp_err   = 1'b0;

        // Reset state
        step();
        step();
        check("ready_in_reset", cmd_ready, 1'b0);
        check("busy_in_reset", busy, 1'b0);
        check("ctrl_a_in_reset", pad_ctrl_a, 13'h0);
        rst = 1'b0;
        #1;
        check_cycle(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);

        // SET_A, then back-to-back SET_S / SET_A with abort high in IDLE
        do_cmd(3'd1, 16'h1ABC, -1);
        cmd_valid = 1'b1;
        abort     = 1'b1;
        cmd_op    = 3'd2;
        cmd_arg   = 16'h0005;
        exp_s     = 4'h5;
        step();
        check_cycle(1'b0, 1'b1, 3'd0, 2'd0, 1'b0);
        cmd_op  = 3'd1;
        cmd_arg = 16'h0123;
        exp_a   = 13'h0123;
        step();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check_cycle(1'b0, 1'b1, 3'd0, 2'd0, 1'b0);
        step();
        check_cycle(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);

        // Pumps, flush, waits, zero-length ops
        do_cmd(3'd3, 16'd2, -1);
        do_cmd(3'd1, 16'h1FFF, -1);
        do_cmd(3'd2, 16'h000F, -1);
        do_cmd(3'd6, 16'd0, -1);
        do_cmd(3'd5, 16'd10, -1);
        do_cmd(3'd5, 16'd0, -1);
        do_cmd(3'd3, 16'd0, -1);
        do_cmd(3'd4, 16'd0, -1);
        do_cmd(3'd4, 16'd1, -1);

        // Aborts: PUMP_B stroke 2 phase 3, FLUSH, WAIT
        do_cmd(3'd2, 16'h000A, -1);
        do_cmd(3'd4, 16'd5, (4 + 2) * P + 1);
        do_cmd(3'd1, 16'h0F0F, -1);
        do_cmd(3'd6, 16'd0, 5);
        do_cmd(3'd5, 16'd30, 12);

        // Reserved op: err is sticky
        do_cmd(3'd7, 16'hFFFF, -1);
        do_cmd(3'd1, 16'h0AAA, -1);
        do_cmd(3'd3, 16'd1, -1);

        // Random commands
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            case (rop)
                3'd3, 3'd4: rarg = 16'($urandom_range(0, 2));
                3'd5:       rarg = 16'($urandom_range(0, 40));
                default:    rarg = 16'($urandom);
            endcase
            rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : -1;
            do_cmd(rop, rarg, rab);
            repeat ($urandom_range(0, 2)) begin
                step();
                check_cycle(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
            end
        end

        // Maximum count completes without wrap
        do_cmd(3'd5, 16'hFFFF, -1);

        // Reset in the middle of PUMP_A
        do_cmd(3'd1, 16'h1234, -1);
        do_cmd(3'd7, 16'd0, -1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_arg   = 16'd3;
        step();
        cmd_valid = 1'b0;
        repeat (10) step();
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        step();
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ctrl_a", pad_ctrl_a, 13'h0);
        check("rst_pump_a", pad_pump_a, 3'h0);
        rst     = 1'b0;
        exp_a   = '0;
        exp_s   = '0;
        exp_err = 1'b0;
        #1;
        check_cycle(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        do_cmd(3'd2, 16'h0003, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
